// File: rtl/cmd_scheduler_pkg.sv
// cmd_scheduler_pkg: shared FSM states, status codes and default timeouts for the CMD scheduler
package cmd_scheduler_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_TX, WAIT_RESP, DONE} state_e;
  typedef enum logic [1:0] {ST_OK, ST_TIMEOUT, ST_CRC_ERR, ST_TX_GUARD} status_e;
  localparam int DEF_TIMEOUT_CYC = 64;
  localparam int DEF_TX_GUARD_CYC = 128;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/cmd_scheduler_if.sv
// cmd_scheduler_if: requester-side and cmd-engine-side signals of the CMD scheduler
interface cmd_scheduler_if;
  logic [1:0] req, gnt, ack, status;
  logic [5:0] index0, index1, phy_index;
  logic [31:0] arg0, arg1, phy_arg, resp, phy_resp;
  logic resp_exp0, resp_exp1, phy_resp_exp, phy_start, phy_done, phy_resp_valid, phy_crc_err;
  modport slave (
    input req, index0, index1, arg0, arg1, resp_exp0, resp_exp1, phy_done, phy_resp_valid, phy_resp, phy_crc_err,
    output gnt, ack, status, resp, phy_start, phy_index, phy_arg, phy_resp_exp
  );
  modport master (
    output req, index0, index1, arg0, arg1, resp_exp0, resp_exp1, phy_done, phy_resp_valid, phy_resp, phy_crc_err,
    input gnt, ack, status, resp, phy_start, phy_index, phy_arg, phy_resp_exp
  );
endinterface

// File: rtl/cmd_scheduler_rr_arb.sv
// cmd_scheduler_rr_arb: 2-way round-robin pick, pointer's requester first
module cmd_scheduler_rr_arb (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] win_o
);
  always_comb begin
    win_o = ptr_i ? (req_i[1] ? 2'b10 : req_i[0] ? 2'b01 : 2'b00)
                  : (req_i[0] ? 2'b01 : req_i[1] ? 2'b10 : 2'b00);
  end
endmodule

// File: rtl/cmd_scheduler.sv
// cmd_scheduler: arbitrates two requesters onto one SD CMD engine and sequences
// start, transmit-done and optional response wait with timeouts.
module cmd_scheduler
  import cmd_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  parameter int TX_GUARD_CYC = DEF_TX_GUARD_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input logic clk,
  input logic rst_n,
  cmd_scheduler_if.slave bus
);
  state_e state_q, state_d;
  status_e status_q, status_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] gnt_q, gnt_d, win;
  logic ptr_q, ptr_d, rexp_q, rexp_d;
  logic [5:0] idx_q, idx_d;
  logic [31:0] arg_q, arg_d, resp_q, resp_d;
  logic tx_tc, rsp_tc;
  cmd_scheduler_rr_arb u_arb (.req_i(bus.req), .ptr_i(ptr_q), .win_o(win));
  // cnt is cleared on entry, so the final waiting cycle is where it reads LIMIT-2
  assign tx_tc  = cnt_q == CNT_W'(TX_GUARD_CYC - 2);
  assign rsp_tc = cnt_q == CNT_W'(TIMEOUT_CYC - 2);
  assign bus.gnt          = gnt_q;
  assign bus.ack          = (state_q == DONE) ? gnt_q : 2'b00;
  assign bus.status       = status_q;
  assign bus.resp         = resp_q;
  assign bus.phy_start    = state_q == ISSUE;
  assign bus.phy_index    = idx_q;
  assign bus.phy_arg      = arg_q;
  assign bus.phy_resp_exp = rexp_q;
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    cnt_d    = &cnt_q ? cnt_q : cnt_q + 1'b1;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    rexp_d   = rexp_q;
    idx_d    = idx_q;
    arg_d    = arg_q;
    resp_d   = resp_q;
    case (state_q)
      IDLE: if (|win) begin
        gnt_d    = win;
        idx_d    = win[1] ? bus.index1 : bus.index0;
        arg_d    = win[1] ? bus.arg1 : bus.arg0;
        rexp_d   = win[1] ? bus.resp_exp1 : bus.resp_exp0;
        status_d = ST_OK;
        resp_d   = '0;
        state_d  = ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_TX;
      end
      WAIT_TX: if (bus.phy_done) begin
        cnt_d   = '0;
        state_d = rexp_q ? WAIT_RESP : DONE;
      end else if (tx_tc) begin
        status_d = ST_TX_GUARD;
        state_d  = DONE;
      end
      WAIT_RESP: if (bus.phy_resp_valid) begin
        resp_d   = bus.phy_resp;
        status_d = bus.phy_crc_err ? ST_CRC_ERR : ST_OK;
        state_d  = DONE;
      end else if (rsp_tc) begin
        resp_d   = '0;
        status_d = ST_TIMEOUT;
        state_d  = DONE;
      end
      DONE: begin
        gnt_d   = 2'b00;
        ptr_d   = gnt_q[0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      status_q <= ST_OK;
      cnt_q    <= '0;
      gnt_q    <= 2'b00;
      ptr_q    <= 1'b0;
      rexp_q   <= 1'b0;
      idx_q    <= '0;
      arg_q    <= '0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      rexp_q   <= rexp_d;
      idx_q    <= idx_d;
      arg_q    <= arg_d;
      resp_q   <= resp_d;
    end
  end
endmodule

// File: tb/tb_cmd_scheduler.sv
// tb_cmd_scheduler: scoreboard bench for cmd_scheduler arbitration, sequencing and timeouts
module tb_cmd_scheduler;
  import cmd_scheduler_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  cmd_scheduler_if bus();
  cmd_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {logic [1:0] gnt; logic [1:0] status; logic [31:0] resp;} exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int max, output logic got, output int c);
    got = 1'b0;
    c = 0;
    while (!got && c <= max) begin
      if (bus.phy_start) got = 1'b1;
      else begin
        tick();
        c++;
      end
    end
  endtask

  task automatic wait_ack(input int max, output logic got, output int c);
    got = 1'b0;
    c = 0;
    while (!got && c <= max) begin
      if (|bus.ack) got = 1'b1;
      else begin
        tick();
        c++;
      end
    end
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({bus.gnt, bus.ack, bus.status, bus.phy_start, bus.phy_resp_exp} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_ctrl: got gnt=%b ack=%b st=%b start=%b rexp=%b want all 0", bus.gnt, bus.ack, bus.status, bus.phy_start, bus.phy_resp_exp);
    end
    n_cmp++;
    if ({bus.resp, bus.phy_arg, bus.phy_index} !== 70'h0) begin
      n_err++;
      $display("FAIL reset_data: got resp=%h arg=%h idx=%h want 0", bus.resp, bus.phy_arg, bus.phy_index);
    end
  endtask

  task automatic test_basic;
    logic got;
    int c;
    exp_t e;
    bus.index0 = 6'd0; bus.arg0 = 32'h0; bus.resp_exp0 = 1'b0; bus.req = 2'b01;
    sb.push_back('{2'b01, 2'(ST_OK), 32'h0});
    wait_start(5, got, c);
    n_cmp++;
    if (!got || c != 1) begin n_err++; $display("FAIL basic_start: got seen=%b lat=%0d want seen=1 lat=1", got, c); end
    n_cmp++;
    if (bus.gnt !== 2'b01) begin n_err++; $display("FAIL basic_gnt: got %b want 01", bus.gnt); end
    repeat (50) tick();
    bus.phy_done = 1'b1;
    tick();
    bus.phy_done = 1'b0;
    wait_ack(0, got, c);
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL basic_ack_latency: got no ack want ack cycle after done"); end
    e = sb.pop_front();
    n_cmp++;
    if ({bus.ack, bus.status, bus.resp} !== {e.gnt, e.status, e.resp}) begin
      n_err++;
      $display("FAIL basic_result: got ack=%b st=%b resp=%h want ack=%b st=%b resp=%h", bus.ack, bus.status, bus.resp, e.gnt, e.status, e.resp);
    end
    bus.req = 2'b00;
    tick();
    n_cmp++;
    if ({bus.gnt, bus.ack} !== 4'b0) begin n_err++; $display("FAIL basic_release: got gnt=%b ack=%b want 0", bus.gnt, bus.ack); end
  endtask

  task automatic test_resp;
    logic got;
    int c;
    exp_t e;
    bus.index1 = 6'd17; bus.arg1 = 32'h0000_0200; bus.resp_exp1 = 1'b1; bus.req = 2'b10;
    sb.push_back('{2'b10, 2'(ST_OK), 32'h0000_0900});
    wait_start(5, got, c);
    n_cmp++;
    if (!got || c != 1) begin n_err++; $display("FAIL resp_start: got seen=%b lat=%0d want seen=1 lat=1", got, c); end
    n_cmp++;
    if ({bus.gnt, bus.phy_index, bus.phy_arg, bus.phy_resp_exp} !== {2'b10, 6'd17, 32'h200, 1'b1}) begin
      n_err++;
      $display("FAIL resp_cmd: got gnt=%b idx=%0d arg=%h rexp=%b want 10 17 00000200 1", bus.gnt, bus.phy_index, bus.phy_arg, bus.phy_resp_exp);
    end
    repeat (5) tick();
    bus.phy_done = 1'b1;
    tick();
    bus.phy_done = 1'b0;
    repeat (19) tick();
    bus.phy_resp_valid = 1'b1; bus.phy_resp = 32'h0000_0900;
    tick();
    bus.phy_resp_valid = 1'b0; bus.phy_resp = 32'h0;
    wait_ack(0, got, c);
    n_cmp++;
    if (!got || bus.phy_index !== 6'd17) begin n_err++; $display("FAIL resp_ack: got ack=%b idx=%0d want ack idx=17", got, bus.phy_index); end
    e = sb.pop_front();
    n_cmp++;
    if ({bus.ack, bus.status, bus.resp} !== {e.gnt, e.status, e.resp}) begin
      n_err++;
      $display("FAIL resp_result: got ack=%b st=%b resp=%h want ack=%b st=%b resp=%h", bus.ack, bus.status, bus.resp, e.gnt, e.status, e.resp);
    end
    bus.req = 2'b00;
    tick();
    n_cmp++;
    if (bus.resp !== 32'h900) begin n_err++; $display("FAIL resp_hold: got %h want 00000900", bus.resp); end
  endtask

  task automatic test_back_to_back;
    logic got;
    int c;
    exp_t e;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.index0 = 6'd1; bus.index1 = 6'd2; bus.resp_exp0 = 1'b0; bus.resp_exp1 = 1'b0;
    sb.push_back('{2'b01, 2'(ST_OK), 32'h0});
    sb.push_back('{2'b10, 2'(ST_OK), 32'h0});
    sb.push_back('{2'b01, 2'(ST_OK), 32'h0});
    bus.req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      wait_start(5, got, c);
      n_cmp++;
      if (!got || c != (i == 0 ? 1 : 2)) begin n_err++; $display("FAIL b2b_start%0d: got seen=%b lat=%0d want seen=1 lat=%0d", i, got, c, i == 0 ? 1 : 2); end
      n_cmp++;
      if ({bus.gnt, bus.phy_index} !== {sb[0].gnt, sb[0].gnt[1] ? 6'd2 : 6'd1}) begin
        n_err++;
        $display("FAIL b2b_gnt%0d: got gnt=%b idx=%0d want gnt=%b", i, bus.gnt, bus.phy_index, sb[0].gnt);
      end
      tick();
      bus.phy_done = 1'b1;
      tick();
      bus.phy_done = 1'b0;
      wait_ack(0, got, c);
      e = sb.pop_front();
      n_cmp++;
      if (!got || {bus.ack, bus.status} !== {e.gnt, e.status}) begin
        n_err++;
        $display("FAIL b2b_ack%0d: got ack=%b st=%b want ack=%b st=%b", i, bus.ack, bus.status, e.gnt, e.status);
      end
    end
    bus.req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_timeout;
    logic got;
    int c;
    exp_t e;
    bus.index0 = 6'd3; bus.resp_exp0 = 1'b1; bus.req = 2'b01;
    sb.push_back('{2'b01, 2'(ST_TIMEOUT), 32'h0});
    wait_start(5, got, c);
    tick();
    bus.phy_done = 1'b1;
    tick();
    bus.phy_done = 1'b0;
    wait_ack(80, got, c);
    n_cmp++;
    if (!got || c != DEF_TIMEOUT_CYC - 1) begin
      n_err++;
      $display("FAIL timeout_latency: got seen=%b after_done=%0d want seen=1 after_done=%0d", got, c + 1, DEF_TIMEOUT_CYC);
    end
    e = sb.pop_front();
    n_cmp++;
    if ({bus.ack, bus.status, bus.resp} !== {e.gnt, e.status, e.resp}) begin
      n_err++;
      $display("FAIL timeout_result: got ack=%b st=%b resp=%h want ack=%b st=%b resp=%h", bus.ack, bus.status, bus.resp, e.gnt, e.status, e.resp);
    end
    bus.req = 2'b00;
    tick();
  endtask

  task automatic test_errors;
    logic got, early;
    int c;
    exp_t e;
    bus.index1 = 6'd9; bus.resp_exp1 = 1'b1; bus.req = 2'b10;
    sb.push_back('{2'b10, 2'(ST_CRC_ERR), 32'h0000_0abc});
    wait_start(5, got, c);
    tick();
    bus.phy_done = 1'b1;
    tick();
    bus.phy_done = 1'b0;
    tick();
    bus.phy_resp_valid = 1'b1; bus.phy_crc_err = 1'b1; bus.phy_resp = 32'h0000_0abc;
    tick();
    bus.phy_resp_valid = 1'b0; bus.phy_crc_err = 1'b0; bus.phy_resp = 32'h0;
    wait_ack(0, got, c);
    e = sb.pop_front();
    n_cmp++;
    if (!got || {bus.ack, bus.status, bus.resp} !== {e.gnt, e.status, e.resp}) begin
      n_err++;
      $display("FAIL crc_result: got ack=%b st=%b resp=%h want ack=%b st=%b resp=%h", bus.ack, bus.status, bus.resp, e.gnt, e.status, e.resp);
    end
    bus.req = 2'b01; bus.resp_exp0 = 1'b1;
    tick();
    sb.push_back('{2'b01, 2'(ST_OK), 32'h0000_5a5a});
    wait_start(5, got, c);
    bus.phy_done = 1'b1;
    tick();
    bus.phy_done = 1'b0;
    tick();
    bus.phy_done = 1'b1;
    tick();
    bus.phy_done = 1'b0;
    early = 1'b0;
    repeat (DEF_TIMEOUT_CYC - 2) begin
      if (|bus.ack) early = 1'b1;
      tick();
    end
    bus.phy_resp_valid = 1'b1; bus.phy_resp = 32'h0000_5a5a;
    tick();
    bus.phy_resp_valid = 1'b0; bus.phy_resp = 32'h0;
    wait_ack(0, got, c);
    n_cmp++;
    if (early || !got) begin n_err++; $display("FAIL tc_ack_timing: got early=%b seen=%b want early=0 seen=1", early, got); end
    e = sb.pop_front();
    n_cmp++;
    if ({bus.ack, bus.status, bus.resp} !== {e.gnt, e.status, e.resp}) begin
      n_err++;
      $display("FAIL tc_result: got ack=%b st=%b resp=%h want ack=%b st=%b resp=%h", bus.ack, bus.status, bus.resp, e.gnt, e.status, e.resp);
    end
    bus.req = 2'b10; bus.resp_exp1 = 1'b0;
    tick();
    sb.push_back('{2'b10, 2'(ST_TX_GUARD), 32'h0});
    wait_start(5, got, c);
    bus.req = 2'b00;
    wait_ack(200, got, c);
    n_cmp++;
    if (!got || c != DEF_TX_GUARD_CYC) begin n_err++; $display("FAIL guard_latency: got seen=%b after_start=%0d want seen=1 after_start=%0d", got, c, DEF_TX_GUARD_CYC); end
    e = sb.pop_front();
    n_cmp++;
    if ({bus.ack, bus.status, bus.resp} !== {e.gnt, e.status, e.resp}) begin
      n_err++;
      $display("FAIL guard_result: got ack=%b st=%b resp=%h want ack=%b st=%b resp=%h", bus.ack, bus.status, bus.resp, e.gnt, e.status, e.resp);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    logic got;
    int c;
    exp_t e;
    bus.index0 = 6'd5; bus.arg0 = 32'hdead_beef; bus.resp_exp0 = 1'b1; bus.req = 2'b01;
    wait_start(5, got, c);
    tick();
    bus.phy_done = 1'b1;
    tick();
    bus.phy_done = 1'b0;
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.gnt, bus.ack, bus.phy_start, bus.phy_resp_exp, bus.status, bus.phy_index, bus.phy_arg, bus.resp} !== 78'h0) begin
      n_err++;
      $display("FAIL rstmid_outputs: got gnt=%b ack=%b start=%b idx=%0d arg=%h want all 0", bus.gnt, bus.ack, bus.phy_start, bus.phy_index, bus.phy_arg);
    end
    bus.req = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
    bus.resp_exp0 = 1'b0; bus.req = 2'b01;
    sb.push_back('{2'b01, 2'(ST_OK), 32'h0});
    wait_start(5, got, c);
    n_cmp++;
    if (!got || bus.gnt !== 2'b01) begin n_err++; $display("FAIL rstmid_regrant: got seen=%b gnt=%b want seen=1 gnt=01", got, bus.gnt); end
    tick();
    bus.phy_done = 1'b1;
    tick();
    bus.phy_done = 1'b0;
    wait_ack(0, got, c);
    e = sb.pop_front();
    n_cmp++;
    if (!got || {bus.ack, bus.status, bus.resp} !== {e.gnt, e.status, e.resp}) begin
      n_err++;
      $display("FAIL rstmid_result: got ack=%b st=%b resp=%h want ack=%b st=%b resp=%h", bus.ack, bus.status, bus.resp, e.gnt, e.status, e.resp);
    end
    bus.req = 2'b00;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.req = 2'b00; bus.index0 = '0; bus.index1 = '0; bus.arg0 = '0; bus.arg1 = '0;
    bus.resp_exp0 = 1'b0; bus.resp_exp1 = 1'b0; bus.phy_done = 1'b0; bus.phy_resp_valid = 1'b0;
    bus.phy_resp = '0; bus.phy_crc_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_resp();
    test_back_to_back();
    test_timeout();
    test_errors();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
